// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RISC-V M-extension execute unit.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle,
// 32 steps per operation. Divide-by-zero and signed overflow complete
// without iterating.
//
// Ports:
//   clk, resetn        rising-edge clock, synchronous active-low reset
//   start_in           request from ID/EX to begin an operation
//   op_in[2:0]         funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   operand_a_in       rs1 (multiplicand / dividend)
//   operand_b_in       rs2 (multiplier / divisor)
//   rd_address_in      destination register
//   flush_in           abort the in-flight operation
//   result_out         operation result (held outside the result cycle)
//   result_valid_out   one-cycle writeback strobe
//   rd_address_out     destination of the completed operation
//   stall_out          holds the IF/ID and ID/EX registers
module ex_muldiv_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_in,
  input  logic [2:0]  op_in,
  input  logic [31:0] operand_a_in,
  input  logic [31:0] operand_b_in,
  input  logic [4:0]  rd_address_in,
  input  logic        flush_in,
  output logic [31:0] result_out,
  output logic        result_valid_out,
  output logic [4:0]  rd_address_out,
  output logic        stall_out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic [4:0]  count_q;
  logic        neg_q;
  logic [31:0] addend_q;   // multiplicand magnitude, or divisor magnitude
  logic [63:0] acc_q;      // {partial product | remainder, multiplier | quotient}
  logic        valid_q;

  // Decode of the incoming request
  logic        is_div_in;
  logic        a_signed_in;
  logic        b_signed_in;
  logic        a_neg_in;
  logic        b_neg_in;
  logic [31:0] a_mag_in;
  logic [31:0] b_mag_in;
  logic        neg_in;
  logic        div_zero_in;
  logic        overflow_in;
  logic        bypass_in;
  logic [31:0] special_in;

  always_comb begin
    is_div_in   = op_in[2];
    a_signed_in = (op_in == 3'b001) || (op_in == 3'b010) ||
                  (op_in == 3'b100) || (op_in == 3'b110);
    b_signed_in = (op_in == 3'b001) || (op_in == 3'b100) || (op_in == 3'b110);
    a_neg_in    = a_signed_in && operand_a_in[31];
    b_neg_in    = b_signed_in && operand_b_in[31];
    a_mag_in    = a_neg_in ? (32'd0 - operand_a_in) : operand_a_in;
    b_mag_in    = b_neg_in ? (32'd0 - operand_b_in) : operand_b_in;
    // Remainder follows the dividend; product and quotient follow the xor
    neg_in      = (is_div_in && op_in[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
    div_zero_in = is_div_in && (operand_b_in == '0);
    overflow_in = is_div_in && !op_in[0] &&
                  (operand_a_in == 32'h8000_0000) && (operand_b_in == '1);
    bypass_in   = div_zero_in || overflow_in;
    if (div_zero_in) begin
      special_in = op_in[1] ? operand_a_in : '1;
    end else begin
      special_in = op_in[1] ? '0 : 32'h8000_0000;
    end
  end

  // One iteration step and the sign-corrected final result
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [33:0] div_trial;
  logic [63:0] div_next;
  logic [63:0] acc_next;
  logic [63:0] prod_final;
  logic [31:0] quo_final;
  logic [31:0] rem_final;
  logic [31:0] final_result;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, addend_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    // Trial subtract of divisor from {remainder, next dividend bit}; a
    // negative result restores by keeping the plain shifted value.
    div_trial = {1'b0, acc_q[63:32], acc_q[31]} - {2'b00, addend_q};
    div_next  = div_trial[33] ? {acc_q[62:0], 1'b0}
                              : {div_trial[31:0], acc_q[30:0], 1'b1};
    acc_next  = op_q[2] ? div_next : mul_next;

    prod_final = neg_q ? (64'd0 - acc_next) : acc_next;
    quo_final  = neg_q ? (32'd0 - acc_next[31:0]) : acc_next[31:0];
    rem_final  = neg_q ? (32'd0 - acc_next[63:32]) : acc_next[63:32];

    if (op_q[2]) begin
      final_result = op_q[1] ? rem_final : quo_final;
    end else begin
      final_result = (op_q[1:0] == 2'b00) ? prod_final[31:0] : prod_final[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      op_q           <= '0;
      rd_q           <= '0;
      count_q        <= '0;
      neg_q          <= 1'b0;
      addend_q       <= '0;
      acc_q          <= '0;
      valid_q        <= 1'b0;
      result_out     <= '0;
      rd_address_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid_q <= 1'b0;
          if (start_in && !flush_in) begin
            op_q    <= op_in;
            rd_q    <= rd_address_in;
            neg_q   <= neg_in;
            count_q <= '0;
            if (bypass_in) begin
              state          <= DONE;
              valid_q        <= 1'b1;
              result_out     <= special_in;
              rd_address_out <= rd_address_in;
            end else begin
              state <= RUN;
              if (is_div_in) begin
                addend_q <= b_mag_in;
                acc_q    <= {32'd0, a_mag_in};
              end else begin
                addend_q <= a_mag_in;
                acc_q    <= {32'd0, b_mag_in};
              end
            end
          end
        end

        RUN: begin
          if (flush_in) begin
            state <= IDLE;
          end else begin
            acc_q <= acc_next;
            if (count_q == 5'd31) begin
              state          <= DONE;
              valid_q        <= 1'b1;
              result_out     <= final_result;
              rd_address_out <= rd_q;
            end else begin
              count_q <= count_q + 5'd1;
            end
          end
        end

        DONE: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // A flush arriving in the result cycle must still cancel the writeback,
  // so the registered strobe is gated by the live flush.
  assign result_valid_out = valid_q && !flush_in;

  assign stall_out = resetn &&
                     (((state == IDLE) && start_in && !flush_in) || (state == RUN));

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  logic        clk;
  logic        resetn;
  logic        start_in;
  logic [2:0]  op_in;
  logic [31:0] operand_a_in;
  logic [31:0] operand_b_in;
  logic [4:0]  rd_address_in;
  logic        flush_in;
  logic [31:0] result_out;
  logic        result_valid_out;
  logic [4:0]  rd_address_out;
  logic        stall_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ex_muldiv_unit dut (
    .clk              (clk),
    .resetn           (resetn),
    .start_in         (start_in),
    .op_in            (op_in),
    .operand_a_in     (operand_a_in),
    .operand_b_in     (operand_b_in),
    .rd_address_in    (rd_address_in),
    .flush_in         (flush_in),
    .result_out       (result_out),
    .result_valid_out (result_valid_out),
    .rd_address_out   (rd_address_out),
    .stall_out        (stall_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model from the ISA definition using wide integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    logic [31:0] r;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = a;
    ib = b;
    r  = '0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = ia / ib;
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = ia % ib;
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int expected_latency(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // Issue one operation from IDLE and follow it to completion.
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp,
                        output int valid_cyc);
    int lat, stalls, exp_lat;
    exp_lat = expected_latency(op, a, b);
    op_in = op; operand_a_in = a; operand_b_in = b; rd_address_in = rd;
    flush_in = 1'b0; start_in = 1'b1;
    #1;
    checks++;
    if (stall_out !== 1'b1) begin
      errors++;
      $display("FAIL %s stall_on_request got %b exp 1", name, stall_out);
    end
    tick;
    // Scramble inputs to prove the request was latched
    start_in = 1'b0; op_in = 3'($urandom); operand_a_in = $urandom;
    operand_b_in = $urandom; rd_address_in = 5'($urandom);
    #1;
    lat = 1; stalls = 1;
    while (result_valid_out !== 1'b1 && lat < 40) begin
      if (stall_out === 1'b1) stalls++;
      tick;
      lat++;
    end
    valid_cyc = cyc;
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency got %0d exp %0d", name, lat, exp_lat);
    end
    checks++;
    if (stalls != exp_lat) begin
      errors++;
      $display("FAIL %s stall_cycles got %0d exp %0d", name, stalls, exp_lat);
    end
    checks++;
    if (result_out !== exp) begin
      errors++;
      $display("FAIL %s result got %h exp %h (op %0d a %h b %h)", name, result_out, exp, op, a, b);
    end
    checks++;
    if (rd_address_out !== rd) begin
      errors++;
      $display("FAIL %s rd got %0d exp %0d", name, rd_address_out, rd);
    end
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL %s stall_in_done got %b exp 0", name, stall_out);
    end
    tick;
    checks++;
    if (result_valid_out !== 1'b0 || result_out !== exp || rd_address_out !== rd) begin
      errors++;
      $display("FAIL %s after_done valid %b result %h rd %0d exp 0 %h %0d",
               name, result_valid_out, result_out, rd_address_out, exp, rd);
    end
  endtask

  // Watch for a bounded number of cycles; any valid pulse is an error.
  task automatic expect_quiet(input string name, input int ncyc);
    int seen;
    seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (result_valid_out !== 1'b0) seen++;
      tick;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL %s unexpected_valid got %0d pulses exp 0", name, seen);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; start_in = 1'b1; flush_in = 1'b0; op_in = 3'd0;
    operand_a_in = 32'd3; operand_b_in = 32'd4; rd_address_in = 5'd9;
    tick; tick;
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got %b exp 0", stall_out);
    end
    checks++;
    if (result_out !== '0 || result_valid_out !== 1'b0 || rd_address_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs result %h valid %b rd %0d exp 0 0 0",
               result_out, result_valid_out, rd_address_out);
    end
    start_in = 1'b0;
    resetn = 1'b1;
    tick;
  endtask

  task automatic test_directed;
    int vc;
    run_op("mul_neg",      3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, vc);
    run_op("mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, vc);
    run_op("mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, vc);
    run_op("mulhsu_m1",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, vc);
    run_op("divu_zero",    3'd5, 32'd100,        32'd0,         5'd9,  32'hFFFF_FFFF, vc);
    run_op("remu_zero",    3'd7, 32'd100,        32'd0,         5'd10, 32'd100,       vc);
    run_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, vc);
    run_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         vc);
    run_op("div_neg",      3'd4, 32'hFFFF_FFF9,  32'd2,         5'd13, 32'hFFFF_FFFD, vc);
    run_op("rem_neg",      3'd6, 32'hFFFF_FFF9,  32'd2,         5'd14, 32'hFFFF_FFFF, vc);
    run_op("divu_big",     3'd5, 32'hFFFF_FFF9,  32'd2,         5'd15, 32'h7FFF_FFFC, vc);
    run_op("div_zero_s",   3'd4, 32'h1234_5678,  32'd0,         5'd16, 32'hFFFF_FFFF, vc);
    run_op("divu_nonovf",  3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'd0,         vc);
  endtask

  task automatic test_random;
    int vc;
    logic [2:0] op;
    logic [31:0] a, b;
    logic [4:0] rd;
    int sel;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom; rd = 5'($urandom);
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'd0 - 32'($urandom_range(1, 1000));
        default: ;
      endcase
      run_op("random", op, a, b, rd, ref_model(op, a, b), vc);
    end
  endtask

  task automatic test_flush_run;
    int vc;
    op_in = 3'd1; operand_a_in = $urandom; operand_b_in = $urandom;
    rd_address_in = 5'd3; start_in = 1'b1; flush_in = 1'b0;
    #1;
    tick;
    start_in = 1'b0;
    repeat (10) tick;
    flush_in = 1'b1;
    #1;
    checks++;
    if (result_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_run valid got %b exp 0", result_valid_out);
    end
    tick;
    flush_in = 1'b0;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_run stall got %b exp 0", stall_out);
    end
    expect_quiet("flush_run", 40);
    run_op("after_flush", 3'd6, 32'hFFFF_FF00, 32'd7, 5'd21,
           ref_model(3'd6, 32'hFFFF_FF00, 32'd7), vc);
  endtask

  task automatic test_flush_done;
    op_in = 3'd0; operand_a_in = 32'd11; operand_b_in = 32'd13;
    rd_address_in = 5'd4; start_in = 1'b1; flush_in = 1'b0;
    #1;
    tick;
    start_in = 1'b0;
    repeat (32) tick;
    checks++;
    if (result_valid_out !== 1'b1) begin
      errors++;
      $display("FAIL flush_done pre_valid got %b exp 1", result_valid_out);
    end
    flush_in = 1'b1;
    #1;
    checks++;
    if (result_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_done suppressed got %b exp 0", result_valid_out);
    end
    tick;
    flush_in = 1'b0;
    #1;
    checks++;
    if (stall_out !== 1'b0 || result_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_done idle stall %b valid %b exp 0 0", stall_out, result_valid_out);
    end
  endtask

  task automatic test_flush_idle;
    op_in = 3'd5; operand_a_in = 32'd50; operand_b_in = 32'd0;
    rd_address_in = 5'd2; start_in = 1'b1; flush_in = 1'b1;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle stall got %b exp 0", stall_out);
    end
    tick;
    start_in = 1'b0; flush_in = 1'b0;
    #1;
    expect_quiet("flush_idle", 40);
  endtask

  task automatic test_reset_mid_run;
    op_in = 3'd4; operand_a_in = 32'h7654_3210; operand_b_in = 32'd9;
    rd_address_in = 5'd30; start_in = 1'b1; flush_in = 1'b0;
    #1;
    tick;
    start_in = 1'b0;
    repeat (20) tick;
    resetn = 1'b0; start_in = 1'b1;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run stall got %b exp 0", stall_out);
    end
    tick;
    start_in = 1'b0;
    #1;
    checks++;
    if (result_out !== '0 || result_valid_out !== 1'b0 || rd_address_out !== '0 || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run outputs result %h valid %b rd %0d stall %b exp 0 0 0 0",
               result_out, result_valid_out, rd_address_out, stall_out);
    end
    resetn = 1'b1;
    expect_quiet("reset_mid_run", 40);
  endtask

  task automatic test_back_to_back;
    int c1, c2, lat;
    logic [31:0] a2, b2;
    a2 = $urandom; b2 = 32'($urandom_range(1, 1 << 20));
    op_in = 3'd3; operand_a_in = 32'hDEAD_BEEF; operand_b_in = 32'h1234_5678;
    rd_address_in = 5'd1; start_in = 1'b1; flush_in = 1'b0;
    #1;
    tick;
    start_in = 1'b0;
    #1;
    lat = 1;
    while (result_valid_out !== 1'b1 && lat < 40) begin tick; lat++; end
    c1 = cyc;
    checks++;
    if (result_out !== ref_model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678)) begin
      errors++;
      $display("FAIL b2b first result got %h exp %h", result_out,
               ref_model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678));
    end
    // Request raised in the result cycle: ignored there, accepted from IDLE
    op_in = 3'd5; operand_a_in = a2; operand_b_in = b2; rd_address_in = 5'd2;
    start_in = 1'b1;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b done_stall got %b exp 0", stall_out);
    end
    tick;
    checks++;
    if (stall_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b idle_stall got %b exp 1", stall_out);
    end
    tick;
    start_in = 1'b0;
    #1;
    lat = 1;
    while (result_valid_out !== 1'b1 && lat < 40) begin tick; lat++; end
    c2 = cyc;
    checks++;
    if (c2 - c1 != 34) begin
      errors++;
      $display("FAIL b2b pulse_gap got %0d exp 34", c2 - c1);
    end
    checks++;
    if (result_out !== ref_model(3'd5, a2, b2) || rd_address_out !== 5'd2) begin
      errors++;
      $display("FAIL b2b second result %h rd %0d exp %h 2", result_out, rd_address_out,
               ref_model(3'd5, a2, b2));
    end
    tick;
  endtask

  initial begin
    resetn = 1'b0; start_in = 1'b0; flush_in = 1'b0; op_in = '0;
    operand_a_in = '0; operand_b_in = '0; rd_address_in = '0;
    test_reset;
    test_directed;
    test_random;
    test_flush_run;
    test_flush_done;
    test_flush_idle;
    test_reset_mid_run;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port resetn, input, 1, reset, synchronous, active-low.
REQ-003 SHALL have port start_in, input, 1, request from ID/EX stage to begin an M-extension operation.
REQ-004 SHALL have port op_in, input, 3, RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port operand_a_in, input, 32, rs1 value (multiplicand/dividend).
REQ-006 SHALL have port operand_b_in, input, 32, rs2 value (multiplier/divisor).
REQ-007 SHALL have port rd_address_in, input, 5, destination register.
REQ-008 SHALL have port flush_in, input, 1, abort the in-flight operation.
REQ-009 SHALL have port result_out, output, 32, operation result.
REQ-010 SHALL have port result_valid_out, output, 1, one-cycle pulse marking result_out/rd_address_out valid for writeback.
REQ-011 SHALL have port rd_address_out, output, 5, destination register of the completed operation.
REQ-012 SHALL have port stall_out, output, 1, holds the IF/ID and ID/EX registers.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 In IDLE with start_in=1 and flush_in=0, SHALL latch op, operands and rd on the clock edge, then go to RUN with iteration counter = 0.
REQ-015 In IDLE, SHALL go directly to DONE (bypassing RUN) when the accepted op is a divide/remainder with operand_b=0, or a signed DIV/REM with a=0x80000000 and b=0xFFFFFFFF.
REQ-016 In RUN, SHALL perform exactly one shift-add (multiply) or restoring-subtract (divide) step per cycle; 32 steps (counter 0..31), then go to DONE.
REQ-017 Signed ops SHALL iterate on operand magnitudes and apply the sign correction when entering DONE: MULH signs both operands; MULHSU signs a only; quotient negated when operand signs differ; remainder takes the sign of the dividend.
REQ-018 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32] of the full 64-bit product.
REQ-019 Divide by zero SHALL return quotient 0xFFFFFFFF (DIV, DIVU) and remainder = dividend (REM, REMU).
REQ-020 Signed overflow SHALL return DIV = 0x80000000 and REM = 0.
REQ-021 In DONE, SHALL assert result_valid_out=1 for exactly one cycle with the final result_out and rd_address_out, then return to IDLE.
REQ-022 Latency from the accepting edge to result_valid_out: 33 cycles in the normal case, 1 cycle in the REQ-015 cases.
REQ-023 stall_out SHALL be combinational and equal (IDLE and start_in and not flush_in) or RUN; it SHALL be 0 in DONE so the pipeline advances on the result cycle.
REQ-024 start_in SHALL be ignored in RUN and DONE; no queuing.
REQ-025 A start in the IDLE cycle that immediately follows DONE SHALL be accepted normally (back-to-back operations).
REQ-026 flush_in=1 in RUN or DONE SHALL return the FSM to IDLE at the next edge and suppress result_valid_out in that cycle; flush_in together with start_in in IDLE SHALL NOT accept the request.
REQ-027 result_out and rd_address_out SHALL hold their last values outside DONE.
REQ-028 All arithmetic SHALL wrap modulo 2^32, or 2^64 for the product, with no saturation.

Reset
REQ-029 While resetn=0 at a clock edge: FSM = IDLE, counter = 0, result_out = 0, result_valid_out = 0, rd_address_out = 0, internal operand/accumulator registers = 0.
REQ-030 While resetn=0, stall_out SHALL be 0 regardless of start_in.
REQ-031 Reset asserted mid-RUN SHALL abandon the operation with no result_valid_out pulse.

Verification
REQ-032 MUL a=7, b=0xFFFFFFFD, rd=5 -> result_valid_out at accept+33, result 0xFFFFFFEB, rd 5; stall_out=1 for 33 cycles.
REQ-033 MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 DIVU a=100, b=0 -> 0xFFFFFFFF at accept+1; REMU same operands -> 100; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at accept+1; REM same operands -> 0.
REQ-035 DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU a=0xFFFFFFF9, b=2 -> 0x7FFFFFFC.
REQ-036 flush_in at RUN cycle 10 -> IDLE at the next edge, stall_out=0, no result_valid_out pulse; a subsequent start completes correctly.
REQ-037 resetn low at RUN cycle 20 for 1 cycle -> all outputs 0 and no result_valid_out pulse; start held high in the IDLE cycle immediately after DONE -> second operation accepted, back-to-back valid pulses 34 cycles apart.
